restoring_divider: RTL and testbench



---
 rtl/div_pkg.sv | 23 ++
 rtl/lookahead_sub.sv | 42 ++++
 rtl/restoring_divider.sv | 147 ++++++++++++++
 tb/tb_restoring_divider.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider and its neighbours in the
// arithmetic datapath: FSM state encoding, default operand width and a
// helper that sizes the iteration counter.
package div_pkg;

  // Default operand / quotient / remainder width.
  localparam int DIV_WIDTH = 8;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bits needed to hold an iteration count of 0 .. width-1 (at least 1).
  function automatic int count_width(input int width);
    int bits;
    bits = $clog2(width);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/lookahead_sub.sv
// Combinational N-bit subtractor, diff = a + ~b + 1.
// Carries are resolved inside 2-bit lookahead groups (group generate and
// propagate) and passed from group to group. An odd width ends with a single
// trailing bit. borrow is the inverted carry out, i.e. borrow = (a < b).
module lookahead_sub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N-1:0] b_inv;
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign b_inv = ~b;
  assign g     = a & b_inv;
  assign p     = a ^ b_inv;

  // The +1 of the two's complement enters as the carry into bit 0.
  assign c[0] = 1'b1;

  for (genvar k = 0; k < N / 2; k++) begin : g_grp
    logic grp_g;
    logic grp_p;
    assign grp_g      = g[2*k+1] | (p[2*k+1] & g[2*k]);
    assign grp_p      = p[2*k+1] & p[2*k];
    assign c[2*k + 1] = g[2*k] | (p[2*k] & c[2*k]);
    assign c[2*k + 2] = grp_g | (grp_p & c[2*k]);
  end

  if (N % 2 == 1) begin : g_tail
    assign c[N] = g[N-1] | (p[N-1] & c[N-1]);
  end

  assign diff   = p ^ c[N-1:0];
  assign borrow = ~c[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider. One dividend/divisor pair is
// accepted through start (only while idle); one quotient bit is retired per
// clock. Results appear on registered outputs together with a one-cycle done
// pulse and hold until the next accepted start.
//
// Handshake: start is sampled only on an edge where busy = 0; that edge
// captures dividend and divisor. busy stays high from the cycle after the
// accepting edge until the cycle after done. Starts seen while busy (including
// the done cycle) are dropped and their operands are never sampled.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = count_width(WIDTH);

  state_t         state_q;
  state_t         state_d;
  logic [CW-1:0]  count;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   t;
  logic             sub_borrow;
  logic             take_diff;
  logic             accept;
  logic             divisor_zero;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  assign accept       = (state_q == IDLE) && start;
  assign divisor_zero = (divisor == '0);
  assign busy         = (state_q != IDLE);

  // Shift the next dividend bit into the partial remainder and trial-subtract D.
  assign s = {r, q[WIDTH-1]};

  lookahead_sub #(
    .N (WIDTH + 1)
  ) u_sub (
    .a      (s),
    .b      ({1'b0, d}),
    .diff   (t),
    .borrow (sub_borrow)
  );

  // While R < D the shifted value S is below 2*D, so a successful difference
  // always fits in WIDTH bits; a set MSB is treated like a borrow so R can
  // never leave its WIDTH-bit range.
  assign take_diff = ~sub_borrow & ~t[WIDTH];
  assign r_next    = take_diff ? t[WIDTH-1:0] : s[WIDTH-1:0];
  assign q_next    = {q[WIDTH-2:0], take_diff};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> CALC (or straight to DONE for a zero divisor),
  // CALC for WIDTH iterations, DONE for exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = divisor_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (count == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Working registers: operand capture on accept, one restoring step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= '0;
      q     <= '0;
      d     <= '0;
      count <= '0;
    end else if (accept) begin
      r     <= '0;
      q     <= dividend;
      d     <= divisor;
      count <= CW'(WIDTH - 1);
    end else if (state_q == CALC) begin
      r     <= r_next;
      q     <= q_next;
      count <= count - CW'(1);
    end
  end

  // Result outputs: loaded on the edge that enters DONE, held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (divisor_zero) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end else begin
          div_by_zero <= 1'b0;
        end
      end else if ((state_q == CALC) && (count == '0)) begin
        // The final iteration's Q and R are the results.
        quotient  <= q_next;
        remainder <= r_next;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider (WIDTH = 8). Inputs are driven on the
// falling edge and outputs are sampled on the falling edge, away from the
// active rising edge. Cycle index k below means "the falling edge after
// rising edge Ek", E0 being the edge that accepts start.
module tb_restoring_divider;
  import div_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks;
  int errors;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation and capture what the DUT reports. lat is the cycle
  // index k at which done was first seen, or -1 if it never came.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] q_o,
                        output logic [W-1:0] r_o, output logic dz_o,
                        output logic done_after, output logic busy_after);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    for (int k = 0; k < 3 * W; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    q_o  = quotient;
    r_o  = remainder;
    dz_o = div_by_zero;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", div_by_zero); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [5];
    logic [W-1:0] tb [5];
    logic [W-1:0] eq [5];
    logic [W-1:0] er [5];
    int lat;
    logic [W-1:0] q_o, r_o;
    logic dz_o, done_after, busy_after;
    ta = '{8'd200, 8'd255, 8'd5, 8'd0, 8'd255};
    tb = '{8'd7,   8'd1,   8'd9, 8'd3, 8'd255};
    eq = '{8'd28,  8'd255, 8'd0, 8'd0, 8'd1};
    er = '{8'd4,   8'd0,   8'd5, 8'd0, 8'd0};
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], lat, q_o, r_o, dz_o, done_after, busy_after);
      checks++; if (lat != W) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, W); end
      checks++; if (q_o !== eq[i]) begin errors++; $display("FAIL basic_quotient[%0d]: got %0d expected %0d", i, q_o, eq[i]); end
      checks++; if (r_o !== er[i]) begin errors++; $display("FAIL basic_remainder[%0d]: got %0d expected %0d", i, r_o, er[i]); end
      checks++; if (dz_o !== 1'b0) begin errors++; $display("FAIL basic_dz[%0d]: got %b expected 0", i, dz_o); end
      checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL basic_done_pulse[%0d]: got %b expected 0", i, done_after); end
      checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after[%0d]: got %b expected 0", i, busy_after); end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [W-1:0] q_o, r_o;
    logic dz_o, done_after, busy_after;
    // Zero divisor goes straight to DONE on the accepting edge.
    run_op(8'd77, 8'd0, lat, q_o, r_o, dz_o, done_after, busy_after);
    checks++; if (lat != 0) begin errors++; $display("FAIL dz_latency: got %0d expected 0", lat); end
    checks++; if (q_o !== 8'd255) begin errors++; $display("FAIL dz_quotient: got %0d expected 255", q_o); end
    checks++; if (r_o !== 8'd77) begin errors++; $display("FAIL dz_remainder: got %0d expected 77", r_o); end
    checks++; if (dz_o !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", dz_o); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL dz_busy_after: got %b expected 0", busy_after); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_hold: got %b expected 1", div_by_zero); end
    run_op(8'd10, 8'd3, lat, q_o, r_o, dz_o, done_after, busy_after);
    checks++; if (q_o !== 8'd3) begin errors++; $display("FAIL dz_next_quotient: got %0d expected 3", q_o); end
    checks++; if (r_o !== 8'd1) begin errors++; $display("FAIL dz_next_remainder: got %0d expected 1", r_o); end
    checks++; if (dz_o !== 1'b0) begin errors++; $display("FAIL dz_next_flag: got %b expected 0", dz_o); end
  endtask

  // Starts arriving mid-CALC and in the done cycle must be dropped.
  task automatic test_busy_ignore();
    int done_seen;
    int first_k;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    @(posedge clk);
    done_seen = 0;
    first_k   = -1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        done_seen++;
        if (first_k < 0) first_k = k;
      end
      if (k == 3 || k == 8) begin
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
      end
      if (k == 0) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy_high: got %b expected 1", busy); end
      end
      if (k == 8) begin
        checks++; if (quotient !== 8'd10) begin errors++; $display("FAIL ignore_quotient: got %0d expected 10", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL ignore_remainder: got %0d expected 0", remainder); end
      end
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    checks++; if (first_k != W) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", first_k, W); end
    checks++; if (done_seen != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_seen); end
    checks++; if (quotient !== 8'd10) begin errors++; $display("FAIL hold_quotient: got %0d expected 10", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL hold_remainder: got %0d expected 0", remainder); end
  endtask

  // start held high with operands changing every edge. DONE occupies the
  // cycle after E8, so the FSM is idle again for E10: accepts at 0, 10, 20.
  task automatic test_back_to_back();
    logic [W-1:0] ta [32];
    logic [W-1:0] tb [32];
    logic exp_done;
    int done_seen;
    for (int k = 0; k < 32; k++) begin
      ta[k] = 8'((k * 37 + 11) % 256);
      tb[k] = 8'((k % 7) + 2);
    end
    done_seen = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      dividend = ta[k];
      divisor  = tb[k];
      @(posedge clk);
      @(negedge clk);
      exp_done = (k == 8) || (k == 18) || (k == 28);
      if (done === 1'b1) done_seen++;
      checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done[%0d]: got %b expected %b", k, done, exp_done); end
      if (exp_done) begin
        checks++; if (quotient !== ta[k-8] / tb[k-8]) begin errors++; $display("FAIL b2b_quotient[%0d]: got %0d expected %0d", k, quotient, ta[k-8] / tb[k-8]); end
        checks++; if (remainder !== ta[k-8] % tb[k-8]) begin errors++; $display("FAIL b2b_remainder[%0d]: got %0d expected %0d", k, remainder, ta[k-8] % tb[k-8]); end
      end
    end
    start = 1'b0;
    checks++; if (done_seen != 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", done_seen); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int done_seen;
    int lat;
    logic [W-1:0] q_o, r_o;
    logic dz_o, done_after, busy_after;
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL abort_quotient: got %0d expected 0", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL abort_remainder: got %0d expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL abort_dz: got %b expected 0", div_by_zero); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_seen); end
    run_op(8'd100, 8'd3, lat, q_o, r_o, dz_o, done_after, busy_after);
    checks++; if (q_o !== 8'd33) begin errors++; $display("FAIL abort_rerun_quotient: got %0d expected 33", q_o); end
    checks++; if (r_o !== 8'd1) begin errors++; $display("FAIL abort_rerun_remainder: got %0d expected 1", r_o); end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b, q_o, r_o;
    logic dz_o, done_after, busy_after;
    int recon;
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_op(a, b, lat, q_o, r_o, dz_o, done_after, busy_after);
      recon = int'(q_o) * int'(b) + int'(r_o);
      checks++; if (recon != int'(a)) begin errors++; $display("FAIL rand_identity[%0d]: %0d/%0d gave q=%0d r=%0d, q*d+r=%0d expected %0d", i, a, b, q_o, r_o, recon, a); end
      checks++; if (r_o >= b) begin errors++; $display("FAIL rand_rem_bound[%0d]: %0d/%0d remainder %0d expected below %0d", i, a, b, r_o, b); end
      checks++; if (lat != W) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, W); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
